uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin packet arbiter that lets up to NUM_REQ client blocks share one UART transmit channel. It grants a whole packet at a time, optionally prefixes each packet with a source-ID header byte, and drives the UART core's tx_data/tx_vld/tx_rdy valid-ready interface through a single registered output stage. It sits between the client logic and the `uart` core's transmit port.

## Interface
- DLY, 1: simulation delay applied to register assignments.
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: byte width; must equal the UART core's DATA_WIDTH.
- HDR_EN, 1: 1 = send a header byte before each packet; 0 = no header.
- HDR_MARK, 8'hA0: header template. The header is HDR_MARK with its low IDXW = clog2(NUM_REQ) bits replaced by the granted index.
- MAX_LEN, 16: maximum number of payload beats per packet, 1..255.

Ports:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, asynchronous and active-high.
- req_data_i, in, NUM_REQ*DATA_WIDTH: requester k drives bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_vld_i, in, NUM_REQ: per-requester beat valid.
- req_last_i, in, NUM_REQ: per-requester last-beat-of-packet flag.
- req_rdy_o, out, NUM_REQ: per-requester ready.
- tx_data_o, out, DATA_WIDTH: byte to the UART core; registered.
- tx_vld_o, out, 1: byte valid; registered.
- tx_rdy_i, in, 1: ready from the UART core.
- grant_o, out, NUM_REQ: one-hot current grant; all zero when idle.
- ovf_o, out, 1: one-cycle pulse when a packet is truncated at MAX_LEN.

## Operation
- Output register (OR):
  - OR is free when tx_vld_o = 0, or when tx_vld_o && tx_rdy_i in the current cycle.
  - tx_data_o holds its value while tx_vld_o && !tx_rdy_i.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If any req_vld_i bit is set, grant the first set bit searching upward from ptr, wrapping modulo NUM_REQ.
  - grant_o updates on the next edge. The next state is HDR if HDR_EN = 1, otherwise DATA.
  - The beat counter cnt is cleared.
- HDR:
  - When OR is free, load the header into OR and go to DATA.
  - req_rdy_o is all zero in this state.
- DATA:
  - req_rdy_o[g] = OR free, where g is the granted index. All other req_rdy_o bits are 0.
  - A beat is accepted on req_vld_i[g] && req_rdy_o[g]. The accepted beat is loaded into OR and cnt increments.
  - If the accepted beat has req_last_i[g] = 1, or cnt+1 == MAX_LEN:
    - ptr <= g+1 mod NUM_REQ.
    - grant_o clears and the FSM returns to IDLE.
    - If the beat ends the packet by MAX_LEN and req_last_i[g] = 0, ovf_o pulses. The requester's remaining beats are arbitrated as a new packet.
- A granted requester that deasserts valid mid-packet keeps the grant indefinitely. There is no timeout.
- Non-granted requesters are never back-pressured into losing data; their ready bit stays 0.
- Reset values:
  - tx_vld_o = 0, tx_data_o = 0.
  - grant_o = 0, req_rdy_o = 0, ovf_o = 0.
  - FSM = IDLE, ptr = 0, cnt = 0.
- Reset mid-packet drops the in-flight byte in OR and the rest of the packet. No partial state survives.

## Timing
- Arbitration takes 1 cycle: valid seen in IDLE at cycle N means grant_o is set at N+1.
- With HDR_EN = 1 and tx_rdy_i = 1:
  - Header on tx_data_o at N+2.
  - First payload byte at N+3.
  - One byte per cycle after that.
- Payload latency: a beat accepted at edge M appears on tx_data_o after edge M, i.e. 1 cycle.
- Turnaround: at least 1 IDLE cycle between packets, so back-to-back packets lose one cycle.
- req_rdy_o is combinational from tx_rdy_i and the FSM state. It has no combinational path from req_vld_i.
- ovf_o is asserted in the cycle after the truncating beat is accepted, for exactly 1 cycle.

## Test plan
- Single packet:
  - Stimulus: NUM_REQ = 4, HDR_EN = 1; requester 2 sends 8'h11, 8'h22, 8'h33 (last on 8'h33); tx_rdy_i = 1.
  - Required: tx stream A2, 11, 22, 33; grant_o = 4'b0100 during the packet, then 0.
- Round-robin fairness:
  - Stimulus: all four requesters continuously send 2-beat packets.
  - Required: grants rotate 0, 1, 2, 3, 0, …, and no index is skipped over 12 packets.
- Backpressure:
  - Stimulus: tx_rdy_i follows a 1-in-3 duty cycle.
  - Required: tx_data_o is stable while stalled; no byte is lost or duplicated; the byte order matches the input.
- MAX_LEN truncation:
  - Stimulus: MAX_LEN = 4; requester 1 sends 6 beats with last on beat 6; HDR_EN = 1.
  - Required: output A1, b1..b4; ovf_o pulses once; then A1, b5, b6.
- No-header mode:
  - Stimulus: HDR_EN = 0; requesters 0 and 3 each send one-beat packets 8'h5A and 8'hC3 simultaneously from reset.
  - Required: output 5A then C3; requester 0 is granted first because ptr = 0.
- Reset mid-packet:
  - Stimulus: assert rst_i during beat 2 of a 5-beat packet.
  - Required: all outputs go to their reset values immediately. After release, a new packet from requester 3 is granted first and emits A3.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin packet arbiter in front of a UART transmit port.
// Grants one requester for a whole packet, optionally prefixes the packet
// with a source-ID header byte, and drives the UART valid/ready interface
// from a single registered output stage.
module uart_tx_arb #(
    parameter int                    DLY        = 1,
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    HDR_EN     = 1,
    parameter logic [DATA_WIDTH-1:0] HDR_MARK   = 8'hA0,
    parameter int                    MAX_LEN    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_vld_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_vld_o,
    input  logic                          tx_rdy_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          ovf_o
);

    localparam int IDXW = $clog2(NUM_REQ);

    // DLY is kept for drop-in compatibility with the existing UART blocks;
    // register updates here are zero-delay.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LEN < 1 || MAX_LEN > 255 || DLY < 0) begin : g_param_chk
        $error("uart_tx_arb: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    logic [IDXW-1:0]       ptr;
    logic [IDXW-1:0]       gidx;
    logic [7:0]            cnt;

    // Output stage registers (p1 = one cycle after acceptance)
    logic [DATA_WIDTH-1:0] tx_data_p1;
    logic                  tx_vld_p1;
    logic [NUM_REQ-1:0]    grant_p1;
    logic                  ovf_p1;

    logic [DATA_WIDTH-1:0] req_byte [NUM_REQ];
    logic                  arb_hit;
    logic [IDXW-1:0]       arb_idx;
    logic [IDXW:0]         cand;
    logic                  or_free;
    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  beat_acc;
    logic                  len_hit;

    // Header byte: template with its low index bits replaced by the source.
    function automatic logic [DATA_WIDTH-1:0] hdr_byte(input logic [IDXW-1:0] idx);
        logic [DATA_WIDTH-1:0] h;
        h            = HDR_MARK;
        h[IDXW-1:0]  = idx;
        return h;
    endfunction

    // Index increment modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
        if (idx == IDXW'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDXW'(1);
    endfunction

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_byte[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_vld  = req_vld_i[gidx];
    assign sel_last = req_last_i[gidx];
    assign sel_data = req_byte[gidx];

    // The output register can take a new byte when empty or draining this cycle.
    assign or_free  = !tx_vld_p1 || tx_rdy_i;
    assign beat_acc = (state == DATA) && sel_vld && or_free;
    assign len_hit  = ({1'b0, cnt} + 9'd1) == 9'(MAX_LEN);

    // Round-robin search starting at ptr; lowest offset from ptr wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NUM_REQ)) begin
                cand = cand - (IDXW+1)'(NUM_REQ);
            end
            if (req_vld_i[cand[IDXW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[IDXW-1:0];
            end
        end
    end

    // Ready goes only to the granted requester, and only while payload flows.
    always_comb begin
        req_rdy_o = '0;
        if (state == DATA && or_free) begin
            req_rdy_o[gidx] = 1'b1;
        end
    end

    // Packet FSM and output stage: accepted beat -> p1 register -> UART.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            cnt        <= '0;
            tx_data_p1 <= '0;
            tx_vld_p1  <= 1'b0;
            grant_p1   <= '0;
            ovf_p1     <= 1'b0;
        end else begin
            ovf_p1 <= 1'b0;
            if (tx_vld_p1 && tx_rdy_i) begin
                tx_vld_p1 <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (arb_hit) begin
                        gidx     <= arb_idx;
                        grant_p1 <= NUM_REQ'(1) << arb_idx;
                        state    <= (HDR_EN != 0) ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (or_free) begin
                        tx_data_p1 <= hdr_byte(gidx);
                        tx_vld_p1  <= 1'b1;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (beat_acc) begin
                        tx_data_p1 <= sel_data;
                        tx_vld_p1  <= 1'b1;
                        cnt        <= cnt + 8'd1;
                        if (sel_last || len_hit) begin
                            // Packet ends; a MAX_LEN cut without last flags overflow and
                            // leaves the remaining beats for a fresh arbitration round.
                            ptr      <= wrap_inc(gidx);
                            grant_p1 <= '0;
                            ovf_p1   <= !sel_last;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_data_o = tx_data_p1;
    assign tx_vld_o  = tx_vld_p1;
    assign grant_o   = grant_p1;
    assign ovf_o     = ovf_p1;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-driven requesters, a packet-level model of the
// arbitration order, and a per-cycle monitor comparing the UART side.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req_data;
    logic [3:0]  req_vld;
    logic [3:0]  req_last;
    logic        tx_rdy;

    logic [3:0]  a_req_rdy, b_req_rdy, m_req_rdy;
    logic [7:0]  a_tx_data, b_tx_data, m_tx_data;
    logic        a_tx_vld, b_tx_vld, m_tx_vld;
    logic [3:0]  a_grant, b_grant, m_grant;
    logic        a_ovf, b_ovf, m_ovf;
    logic        sel;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .HDR_EN(1), .MAX_LEN(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_vld_i(req_vld),
        .req_last_i(req_last), .req_rdy_o(a_req_rdy), .tx_data_o(a_tx_data),
        .tx_vld_o(a_tx_vld), .tx_rdy_i(tx_rdy), .grant_o(a_grant), .ovf_o(a_ovf));

    uart_tx_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .HDR_EN(0), .MAX_LEN(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_vld_i(req_vld),
        .req_last_i(req_last), .req_rdy_o(b_req_rdy), .tx_data_o(b_tx_data),
        .tx_vld_o(b_tx_vld), .tx_rdy_i(tx_rdy), .grant_o(b_grant), .ovf_o(b_ovf));

    assign m_req_rdy = sel ? b_req_rdy : a_req_rdy;
    assign m_tx_data = sel ? b_tx_data : a_tx_data;
    assign m_tx_vld  = sel ? b_tx_vld  : a_tx_vld;
    assign m_grant   = sel ? b_grant   : a_grant;
    assign m_ovf     = sel ? b_ovf     : a_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] rq [4][$];      // per-requester beats {last, data}
    logic [7:0] exp_d [$];
    bit         exp_t [$];
    int         exp_g [$];
    int         m_ptr = 0;
    int         m_idx = 0;
    int         m_gi  = 0;
    bit         chk_en = 0;
    int         rdy_mode = 0;
    bit [3:0]   hs;
    bit         p_vld, p_rdy;
    logic [7:0] p_data;
    logic [3:0] p_grant;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic load(input int k, input logic [7:0] d, input bit last);
        rq[k].push_back({last, d});
    endtask

    // Packet-level model: who is served in which order and what bytes go out.
    task automatic build_expect(input int hdr_en, input int max_len);
        logic [8:0] mq [4][$];
        logic [8:0] b;
        int  g, n;
        bit  found, fin;
        for (int k = 0; k < 4; k++) mq[k] = rq[k];
        exp_d.delete(); exp_t.delete(); exp_g.delete();
        while (1) begin
            found = 0; g = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && mq[(m_ptr + i) % 4].size() > 0) begin
                    found = 1;
                    g = (m_ptr + i) % 4;
                end
            end
            if (!found) break;
            exp_g.push_back(g);
            if (hdr_en != 0) begin
                exp_d.push_back(8'hA0 | 8'(g));
                exp_t.push_back(1'b0);
            end
            n = 0; fin = 0;
            while (!fin && mq[g].size() > 0) begin
                b = mq[g].pop_front();
                n++;
                fin = b[8] || (n == max_len);
                exp_d.push_back(b[7:0]);
                exp_t.push_back(fin && !b[8]);
            end
            m_ptr = (g + 1) % 4;
        end
    endtask

    task automatic start_phase(input int hdr_en, input int max_len);
        build_expect(hdr_en, max_len);
        m_idx = 0; m_gi = 0;
        p_vld = 0; p_rdy = 0; p_data = '0; p_grant = '0;
        chk_en = 1;
    endtask

    task automatic finish_phase(input int budget, input string nm);
        int c;
        c = 0;
        while ((m_idx < exp_d.size() || m_gi < exp_g.size()) && c < budget) begin
            @(negedge clk); #3;
            c++;
        end
        check(c < budget, {nm, "_done"}, m_idx, exp_d.size());
        repeat (3) begin @(negedge clk); #3; end
        check(m_tx_vld == 1'b0 && m_grant == 4'b0, {nm, "_idle"}, {m_tx_vld, m_grant}, 0);
        chk_en = 0;
    endtask

    task automatic check_reset_vals(input string nm);
        check(a_tx_vld == 0 && b_tx_vld == 0, {nm, "_tx_vld"}, {a_tx_vld, b_tx_vld}, 0);
        check(a_tx_data == 0 && b_tx_data == 0, {nm, "_tx_data"}, {a_tx_data, b_tx_data}, 0);
        check(a_grant == 0 && b_grant == 0, {nm, "_grant"}, {a_grant, b_grant}, 0);
        check(a_req_rdy == 0 && b_req_rdy == 0, {nm, "_rdy"}, {a_req_rdy, b_req_rdy}, 0);
        check(a_ovf == 0 && b_ovf == 0, {nm, "_ovf"}, {a_ovf, b_ovf}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1;
        for (int k = 0; k < 4; k++) rq[k].delete();
        m_ptr = 0;
        repeat (2) @(negedge clk);
        #2 rst = 0;
    endtask

    // Requester driver: present queue heads at negedge, pop after a handshake.
    initial begin
        int cyc;
        cyc = 0;
        req_vld = '0; req_last = '0; req_data = '0; tx_rdy = 1'b1; hs = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            tx_rdy = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            for (int k = 0; k < 4; k++) begin
                if (rq[k].size() > 0) begin
                    req_vld[k]          = 1'b1;
                    req_data[k*8 +: 8]  = rq[k][0][7:0];
                    req_last[k]         = rq[k][0][8];
                end else begin
                    req_vld[k]          = 1'b0;
                    req_data[k*8 +: 8]  = 8'h00;
                    req_last[k]         = 1'b0;
                end
            end
            #1;
            for (int k = 0; k < 4; k++) hs[k] = req_vld[k] && m_req_rdy[k];
        end
    end

    // Monitor: compare the UART side and grants against the model each cycle.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (chk_en && !rst) begin
                if (p_vld && !p_rdy)
                    check(m_tx_vld && m_tx_data == p_data, "hold", {m_tx_vld, m_tx_data}, {1'b1, p_data});
                if (m_tx_vld && (!p_vld || p_rdy) && m_idx < exp_d.size())
                    check(m_ovf == exp_t[m_idx], "ovf", m_ovf, exp_t[m_idx]);
                else
                    check(m_ovf == 1'b0, "ovf_quiet", m_ovf, 0);
                if (m_tx_vld && tx_rdy) begin
                    check(m_idx < exp_d.size(), "byte_count", m_idx, exp_d.size());
                    if (m_idx < exp_d.size()) begin
                        check(m_tx_data == exp_d[m_idx], "tx_byte", m_tx_data, exp_d[m_idx]);
                        m_idx++;
                    end
                end
                if (m_grant != 4'b0 && p_grant == 4'b0) begin
                    check(m_gi < exp_g.size(), "grant_count", m_gi, exp_g.size());
                    if (m_gi < exp_g.size()) begin
                        check(m_grant == (4'b1 << exp_g[m_gi]), "grant", m_grant, 4'b1 << exp_g[m_gi]);
                        m_gi++;
                    end
                end
                check($countones(m_grant) <= 1 && (m_req_rdy & ~m_grant) == 4'b0, "grant_rdy",
                      {m_grant, m_req_rdy}, {m_grant, m_req_rdy & m_grant});
                p_vld = m_tx_vld; p_rdy = tx_rdy; p_data = m_tx_data; p_grant = m_grant;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, required fewer", 40000);
        $fatal(1);
    end

    initial begin
        logic [3:0] eg [5];
        logic [7:0] ed [5];
        logic [7:0] lit [12];
        bit         seen;

        sel = 0;
        #1 rst = 1;
        #2 check_reset_vals("por");
        @(negedge clk); #2 rst = 0;

        // No-header mode: requesters 0 and 3 together, ptr = 0 serves 0 first.
        @(posedge clk); #2;
        sel = 1;
        load(0, 8'h5A, 1); load(3, 8'hC3, 1);
        start_phase(0, 16);
        check(exp_d.size() == 2 && exp_d[0] == 8'h5A && exp_d[1] == 8'hC3, "pin_nohdr",
              {exp_d[0], exp_d[1]}, 16'h5AC3);
        check(exp_g[0] == 0 && exp_g[1] == 3, "pin_nohdr_g", {exp_g[0], exp_g[1]}, {32'd0, 32'd3});
        finish_phase(100, "nohdr");
        sel = 0;
        do_reset();

        // Single packet from requester 2 with cycle-exact timing.
        @(posedge clk); #2;
        load(2, 8'h11, 0); load(2, 8'h22, 0); load(2, 8'h33, 1);
        start_phase(1, 4);
        ed[0] = 8'hA2; ed[1] = 8'h11; ed[2] = 8'h22; ed[3] = 8'h33; ed[4] = 8'h00;
        for (int i = 0; i < 4; i++) check(exp_d[i] == ed[i], "pin_single", exp_d[i], ed[i]);
        eg[0] = 4'b0100; eg[1] = 4'b0100; eg[2] = 4'b0100; eg[3] = 4'b0100; eg[4] = 4'b0000;
        @(negedge clk); #3;
        @(negedge clk); #3;
        check(a_grant == eg[0] && a_tx_vld == 1'b0, "single_arb", {a_grant, a_tx_vld}, {eg[0], 1'b0});
        for (int s = 1; s < 5; s++) begin
            @(negedge clk); #3;
            check(a_grant == eg[s], "single_grant", a_grant, eg[s]);
            check(a_tx_vld && a_tx_data == ed[s-1], "single_tx", {a_tx_vld, a_tx_data}, {1'b1, ed[s-1]});
        end
        finish_phase(100, "single");

        // Round-robin: four requesters, three 2-beat packets each.
        do_reset();
        @(posedge clk); #2;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 4; k++) begin
                load(k, 8'(k*16 + p*2), 0);
                load(k, 8'(k*16 + p*2 + 1), 1);
            end
        start_phase(1, 4);
        check(exp_g.size() == 12, "pin_rr_n", exp_g.size(), 12);
        for (int i = 0; i < 12; i++) check(exp_g[i] == i % 4, "pin_rr_g", exp_g[i], i % 4);
        finish_phase(600, "rr");

        // Backpressure: UART ready one cycle in three.
        rdy_mode = 1;
        @(posedge clk); #2;
        load(0, 8'hC0, 0); load(0, 8'hC1, 1);
        load(1, 8'hD0, 0); load(1, 8'hD1, 0); load(1, 8'hD2, 1);
        load(3, 8'hE0, 1); load(3, 8'hE1, 0); load(3, 8'hE2, 1);
        start_phase(1, 4);
        lit[0] = 8'hA0; lit[1] = 8'hC0; lit[2]  = 8'hC1; lit[3]  = 8'hA1;
        lit[4] = 8'hD0; lit[5] = 8'hD1; lit[6]  = 8'hD2; lit[7]  = 8'hA3;
        lit[8] = 8'hE0; lit[9] = 8'hA3; lit[10] = 8'hE1; lit[11] = 8'hE2;
        check(exp_d.size() == 12, "pin_bp_n", exp_d.size(), 12);
        for (int i = 0; i < 12; i++) check(exp_d[i] == lit[i], "pin_bp", exp_d[i], lit[i]);
        finish_phase(600, "bp");
        rdy_mode = 0;

        // MAX_LEN truncation: six beats from requester 1 with MAX_LEN = 4.
        @(posedge clk); #2;
        for (int i = 1; i <= 6; i++) load(1, 8'(8'hB0 + i), i == 6);
        start_phase(1, 4);
        lit[0] = 8'hA1; lit[1] = 8'hB1; lit[2] = 8'hB2; lit[3] = 8'hB3;
        lit[4] = 8'hB4; lit[5] = 8'hA1; lit[6] = 8'hB5; lit[7] = 8'hB6;
        check(exp_d.size() == 8, "pin_trunc_n", exp_d.size(), 8);
        for (int i = 0; i < 8; i++) check(exp_d[i] == lit[i], "pin_trunc", exp_d[i], lit[i]);
        check(exp_t[4] == 1'b1 && exp_t.sum() with (int'(item)) == 1, "pin_trunc_ovf", exp_t[4], 1);
        finish_phase(200, "trunc");

        // Reset in the middle of a 5-beat packet, then requester 3 alone.
        @(posedge clk); #2;
        for (int i = 1; i <= 5; i++) load(1, 8'(8'h70 + i), i == 5);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk); #3;
            seen = a_tx_vld && a_tx_data == 8'h72;
        end
        check(seen, "mid_beat2", a_tx_data, 8'h72);
        rst = 1;
        for (int k = 0; k < 4; k++) rq[k].delete();
        m_ptr = 0;
        #1 check_reset_vals("mid_rst");
        @(negedge clk); #3;
        check_reset_vals("mid_hold");
        rst = 0;
        @(posedge clk); #2;
        load(3, 8'h31, 0); load(3, 8'h32, 0); load(3, 8'h33, 1);
        start_phase(1, 4);
        check(exp_d[0] == 8'hA3 && exp_g[0] == 3, "pin_after_rst", {exp_d[0], 8'(exp_g[0])}, 16'hA303);
        finish_phase(100, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
